// File: rtl/disparity_frame_ctrl_if.sv
// Handshake bundle between the frame sequencer, the camera FIFO, the frame RAMs and the disparity core.
// The master modport is the sequencer side; the slave modport is the environment side.
interface disparity_frame_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic              enable;
    logic              buffer_ready;
    logic              fifo_rd;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              image_sel;
    logic              core_start;
    logic              core_idle;
    logic              busy;
    logic              done;
    logic [7:0]        frame_count;

    modport master (
        input  enable, buffer_ready, core_idle,
        output fifo_rd, wr_en, wr_addr, image_sel, core_start, busy, done, frame_count
    );

    modport slave (
        output enable, buffer_ready, core_idle,
        input  fifo_rd, wr_en, wr_addr, image_sel, core_start, busy, done, frame_count
    );
endinterface

// File: rtl/disparity_frame_ctrl.sv
// Captures a left then a right frame from the camera FIFO into the frame RAMs, then runs the disparity core.
// Define DISP_CTRL_CONTINUOUS_EN to loop capture/compute forever after the first enable.
module disparity_frame_ctrl #(
    parameter int WIDTH  = 46,
    parameter int HEIGHT = 30,
    parameter int ADDR_W = 11
) (
    input logic                    clk,
    input logic                    reset,
    disparity_frame_ctrl_if.master bus
);
    localparam int                PIXELS   = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SWAP,
        START,
        COMPUTE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              fifo_rd;
    logic [ADDR_W-1:0] rd_cnt;
    logic              image_sel;
    logic              seen_busy;
    logic [7:0]        frame_count;
    logic              wr_en_p1;
    logic [ADDR_W-1:0] wr_addr_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fifo_rd    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable) state_next = READ;
            end
            READ: begin
                fifo_rd = bus.buffer_ready;
                if (bus.buffer_ready && rd_cnt == LAST_PIX) state_next = SWAP;
            end
            SWAP: begin
                state_next = image_sel ? START : READ;
            end
            START: begin
                state_next = COMPUTE;
            end
            COMPUTE: begin
                // A core that never drops idle after the start pulse keeps us here by design.
                if (seen_busy && bus.core_idle) state_next = DONE;
            end
            DONE: begin
`ifdef DISP_CTRL_CONTINUOUS_EN
                state_next = READ;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt      <= '0;
            image_sel   <= 1'b0;
            seen_busy   <= 1'b0;
            frame_count <= '0;
            wr_en_p1    <= 1'b0;
            wr_addr_p1  <= '0;
        end else begin
            // p1: RAM write lags the FIFO read strobe by one cycle while data arrives
            wr_en_p1   <= fifo_rd;
            wr_addr_p1 <= rd_cnt;
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        rd_cnt    <= '0;
                        image_sel <= 1'b0;
                    end
                end
                READ: begin
                    // Hold on the last pixel so the counter never wraps inside a frame.
                    if (fifo_rd && rd_cnt != LAST_PIX) rd_cnt <= rd_cnt + 1'b1;
                end
                SWAP: begin
                    if (!image_sel) begin
                        image_sel <= 1'b1;
                        rd_cnt    <= '0;
                    end
                end
                START: begin
                    seen_busy <= 1'b0;
                end
                COMPUTE: begin
                    if (!bus.core_idle) seen_busy <= 1'b1;
                end
                DONE: begin
                    frame_count <= frame_count + 1'b1;
`ifdef DISP_CTRL_CONTINUOUS_EN
                    rd_cnt    <= '0;
                    image_sel <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.fifo_rd     = fifo_rd;
    assign bus.wr_en       = wr_en_p1;
    assign bus.wr_addr     = wr_addr_p1;
    assign bus.image_sel   = image_sel;
    assign bus.core_start  = (state == START);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.frame_count = frame_count;
endmodule
